instr_encode_loader: RTL and testbench
======================================

# instr_encode_loader

Sequential instruction encoder and program loader, the inverse of the pipeline's opcode/funct decoder. It accepts abstract instructions (operation select plus operand fields) over a valid/ready handshake and packs them into 32-bit words. Every code emitted decodes back to the same operation. It writes the words to consecutive instruction-memory addresses and holds the processor in reset until the load completes. It sits between the test/boot host and instruction memory.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity 2^ADDR_WIDTH words
- BASE_ADDR, 0, first word address written
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins or restarts a load
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder accepts this cycle
- in_last  in  1  qualifies the final instruction of the program
- op_sel  in  5  operation code, see Operation
- rs, rt, rd, shamt  in  5 each  register and shift fields
- imm  in  16  immediate
- target  in  26  jump target
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_WIDTH  write address
- imem_wdata  out  32  encoded word
- cpu_hold  out  1  holds the pipeline in reset
- busy  out  1  high in LOAD or DRAIN
- done  out  1  load finished (level)
- err  out  1  sticky; an illegal op_sel was received
- word_count  out  ADDR_WIDTH+1  words written since start
- checksum  out  32  running XOR of written words

## Operation
- op_sel map, R-format {000000,rs,rt,rd,shamt,funct}:
  - 0 add 100000, 1 sub 100010, 2 slt 101010, 3 and 100100, 4 or 100101
  - 5 xor 100110, 6 sll 000001, 7 srl 000010, 8 sra 000011, 9 sllv 000100
  - 10 srlv 000110, 11 srav 100001, 12 mult 011000
- op_sel map, I-format {op,rs,rt,imm}:
  - 13 addi 001000, 14 andi 001100, 15 ori 001101, 16 slti 001010, 17 xori 001110
  - 18 lw 100011, 19 sw 101011, 20 beq 000100, 21 bne 000101
  - 24 jr 111101, 25 push 111111, 26 pop 111110
- op_sel map, J-format {op,target}: 22 j 000010, 23 jal 000011.
- op_sel 27–31 are illegal.
- Fields not used by a format are ignored. Unused bit positions are never driven from unrelated inputs.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: entered on reset; in_ready=0.
  - start in any state → LOAD. Clears word_count, err, done, checksum and the internal accept count. The write pointer goes to BASE_ADDR.
  - LOAD: in_ready=1 while accept count < 2^ADDR_WIDTH.
  - LOAD → DRAIN when the accepted item has in_last=1, fills capacity, or is illegal.
  - DRAIN → DONE after one cycle.
  - DONE: done=1. Stays in DONE until start or reset.
- Legal accept: the encoded word is registered and written. The pointer increments, wrapping modulo 2^ADDR_WIDTH. word_count increments.
- Illegal accept: nothing is written, err=1, the load aborts.
- cpu_hold is 1 in IDLE, LOAD and DRAIN. In DONE, cpu_hold = err.
- Capacity reached without in_last: treated as last.

## Timing
- Reset values:
  - state IDLE
  - in_ready, imem_we, busy, done, err = 0
  - imem_addr, imem_wdata, word_count, checksum = 0
  - cpu_hold = 1
- Accept in cycle N (in_valid & in_ready) → imem_we=1 for exactly cycle N+1, with imem_addr/imem_wdata valid. word_count and checksum update at the end of N+1.
- Back-to-back accepts sustain one write per cycle.
- Final or illegal accept at N → DRAIN at N+1, DONE/done=1 at N+2, cpu_hold per err from N+2.
- start coincident with in_valid: start wins, in_ready=0 that cycle, no accept.
- start during DRAIN suppresses the pending write.
- reset mid-load: write suppressed, all outputs return to reset values next cycle.

## Configuration
- INSTR_LOADER_CHECKSUM_EN defined: checksum holds the XOR of all words written since start.
- INSTR_LOADER_CHECKSUM_EN undefined: the checksum register is absent and checksum is tied to 0.

## Test plan
- start; op_sel=13, rs=8, rt=9, imm=0x0005, in_last=1 → addr 0 written 0x21090005; done two cycles after accept; cpu_hold=0; word_count=1.
- op_sel=0, rs=1, rt=2, rd=3, shamt=0, then op_sel=22, target=0x0000010 with in_last → 0x00221820 @0, 0x08000010 @1. With the macro, checksum=0x08221830.
- ADDR_WIDTH=2, five legal items, no in_last → four writes @0–3. in_ready low after the fourth accept; fifth not consumed; word_count=4; done=1.
- Second item op_sel=28 → only @0 written; err=1, done=1, cpu_hold stays 1.
- start after three writes, then one item → that item written at @0; word_count=1; err=0.
- reset asserted the cycle after an accept → no imem_we; outputs at reset values; cpu_hold=1.

Source files
------------

// File: rtl/instr_encode_loader.sv
// Packs abstract instructions into 32-bit words and streams them into instruction memory.
// Define INSTR_LOADER_CHECKSUM_EN to keep a running XOR of written words on checksum.
module instr_encode_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [4:0]            op_sel,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            shamt,
  input  logic [15:0]           imm,
  input  logic [25:0]           target,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [31:0]           checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;

  localparam logic [ADDR_WIDTH-1:0] BASE     = BASE_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH:0]   LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   acc_cnt;
  logic                  we_q;
  logic                  accept;
  logic                  enc_legal;
  logic [31:0]           enc_word;
  logic [5:0]            opcode;
  logic [5:0]            funct;
  fmt_t                  fmt;

  // A restart or reset in the write cycle cancels the strobe already queued.
  assign imem_we  = we_q && !start && !reset;
  assign in_ready = (state == LOAD) && (acc_cnt <= LAST_IDX) && !start && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    enc_legal = 1'b1;
    opcode    = 6'b000000;
    funct     = 6'b000000;
    fmt       = FMT_R;
    case (op_sel)
      5'd0:  funct = 6'b100000;
      5'd1:  funct = 6'b100010;
      5'd2:  funct = 6'b101010;
      5'd3:  funct = 6'b100100;
      5'd4:  funct = 6'b100101;
      5'd5:  funct = 6'b100110;
      5'd6:  funct = 6'b000001;
      5'd7:  funct = 6'b000010;
      5'd8:  funct = 6'b000011;
      5'd9:  funct = 6'b000100;
      5'd10: funct = 6'b000110;
      5'd11: funct = 6'b100001;
      5'd12: funct = 6'b011000;
      5'd13: begin fmt = FMT_I; opcode = 6'b001000; end
      5'd14: begin fmt = FMT_I; opcode = 6'b001100; end
      5'd15: begin fmt = FMT_I; opcode = 6'b001101; end
      5'd16: begin fmt = FMT_I; opcode = 6'b001010; end
      5'd17: begin fmt = FMT_I; opcode = 6'b001110; end
      5'd18: begin fmt = FMT_I; opcode = 6'b100011; end
      5'd19: begin fmt = FMT_I; opcode = 6'b101011; end
      5'd20: begin fmt = FMT_I; opcode = 6'b000100; end
      5'd21: begin fmt = FMT_I; opcode = 6'b000101; end
      5'd22: begin fmt = FMT_J; opcode = 6'b000010; end
      5'd23: begin fmt = FMT_J; opcode = 6'b000011; end
      5'd24: begin fmt = FMT_I; opcode = 6'b111101; end
      5'd25: begin fmt = FMT_I; opcode = 6'b111111; end
      5'd26: begin fmt = FMT_I; opcode = 6'b111110; end
      default: enc_legal = 1'b0;
    endcase
    case (fmt)
      FMT_I:   enc_word = {opcode, rs, rt, imm};
      FMT_J:   enc_word = {opcode, target};
      default: enc_word = {6'b000000, rs, rt, rd, shamt, funct};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= BASE;
      acc_cnt    <= '0;
      we_q       <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
    end else if (start) begin
      state      <= LOAD;
      ptr        <= BASE;
      acc_cnt    <= '0;
      we_q       <= 1'b0;
      word_count <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      we_q <= 1'b0;
      if (we_q) word_count <= word_count + 1'b1;
      case (state)
        LOAD: begin
          if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (enc_legal) begin
              we_q       <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= enc_word;
              ptr        <= ptr + 1'b1;
            end else begin
              err <= 1'b1;
            end
            // Filling the last slot ends the load just like an explicit last item.
            if (!enc_legal || in_last || acc_cnt == LAST_IDX) state <= DRAIN;
          end
        end
        DRAIN: begin
          state    <= DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
          cpu_hold <= err;
        end
        default: ;
      endcase
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start) checksum <= '0;
    else if (we_q)      checksum <= checksum ^ imem_wdata;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader at a 4-word capacity.
module tb_instr_encode_loader;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset, start, in_valid, in_last;
  logic in_ready;
  logic [4:0] op_sel, rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic imem_we, cpu_hold, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata, checksum;
  logic [AW:0] word_count;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t sb[$];
  logic [AW-1:0] model_ptr;
  int check_count = 0;
  int pass_count = 0;

  instr_encode_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .target(target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .word_count(word_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  // Reference encoding built from the opcode/funct tables, independent of the DUT.
  function automatic logic [32:0] modelEncode(input logic [4:0] op, input logic [4:0] a,
      input logic [4:0] b, input logic [4:0] d, input logic [4:0] sh,
      input logic [15:0] im, input logic [25:0] tg);
    logic [5:0] rtab [0:12];
    logic [5:0] itab [13:26];
    rtab = '{6'h20, 6'h22, 6'h2a, 6'h24, 6'h25, 6'h26, 6'h01, 6'h02, 6'h03, 6'h04, 6'h06, 6'h21, 6'h18};
    itab = '{6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0e, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3d, 6'h3f, 6'h3e};
    if (op <= 5'd12) return {1'b1, 6'd0, a, b, d, sh, rtab[op]};
    if (op == 5'd22 || op == 5'd23) return {1'b1, itab[op], tg};
    if (op <= 5'd26) return {1'b1, itab[op], a, b, im};
    return {1'b0, 32'd0};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #2;
  endtask

  task automatic startPulse();
    start = 1'b1;
    sb.delete();
    model_ptr = '0;
    step();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [4:0] a, input logic [4:0] b,
      input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im, input logic [25:0] tg,
      input logic last, input logic expect_accept, input int budget);
    logic got;
    logic [32:0] e;
    op_sel = op; rs = a; rt = b; rd = d; shamt = sh; imm = im; target = tg;
    in_last = last; in_valid = 1'b1; got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      sample();
      if (in_ready) begin
        got = 1'b1;
        e = modelEncode(op, a, b, d, sh, im, tg);
        if (e[32]) begin
          sb.push_back('{addr: model_ptr, data: e[31:0]});
          model_ptr = model_ptr + 1'b1;
        end
      end
      step();
      if (got) break;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    checkOutput("accept", {31'd0, got}, {31'd0, expect_accept});
  endtask

  // Every observed write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    #1;
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_we", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = sb.pop_front();
        checkOutput("wr_addr", {{(32-AW){1'b0}}, imem_addr}, {{(32-AW){1'b0}}, w.addr});
        checkOutput("wr_data", imem_wdata, w.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] exp_cks;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    op_sel = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
    model_ptr = '0;
    step(); step();
    reset = 1'b0;
    sample();
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_we", {31'd0, imem_we}, 32'd0);
    checkOutput("rst_flags", {28'd0, busy, done, err, cpu_hold}, 32'h1);
    checkOutput("rst_addr", {{(32-AW){1'b0}}, imem_addr}, 32'd0);
    checkOutput("rst_wdata", imem_wdata, 32'd0);
    checkOutput("rst_count", {{(31-AW){1'b0}}, word_count}, 32'd0);
    checkOutput("rst_cks", checksum, 32'd0);
    step();

    // Single addi with last: done two cycles after the accept.
    startPulse();
    applyStimulus(5'd13, 5'd8, 5'd9, 5'd0, 5'd0, 16'h0005, 26'd0, 1'b1, 1'b1, 4);
    sample();
    checkOutput("t1_drain_done", {31'd0, done}, 32'd0);
    checkOutput("t1_drain_busy", {31'd0, busy}, 32'd1);
    step(); sample();
    checkOutput("t1_done", {31'd0, done}, 32'd1);
    checkOutput("t1_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("t1_busy", {31'd0, busy}, 32'd0);
    checkOutput("t1_count", {{(31-AW){1'b0}}, word_count}, 32'd1);
    step();

    // R-format add then jump, back to back.
    startPulse();
    applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'd0, 1'b0, 1'b1, 4);
    applyStimulus(5'd22, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b1, 1'b1, 4);
    step(); sample();
`ifdef INSTR_LOADER_CHECKSUM_EN
    exp_cks = 32'h08221830;
`else
    exp_cks = 32'h0;
`endif
    checkOutput("t2_count", {{(31-AW){1'b0}}, word_count}, 32'd2);
    checkOutput("t2_cks", checksum, exp_cks);
    checkOutput("t2_done", {31'd0, done}, 32'd1);
    step();

    // Capacity fill without last: the fifth item is never consumed.
    startPulse();
    for (int i = 0; i < 4; i++)
      applyStimulus(5'(i + 1), 5'(i), 5'(i + 4), 5'(i + 8), 5'(i), 16'h0, 26'd0, 1'b0, 1'b1, 4);
    applyStimulus(5'd14, 5'd3, 5'd4, 5'd0, 5'd0, 16'hbeef, 26'd0, 1'b0, 1'b0, 4);
    sample();
    checkOutput("t3_count", {{(31-AW){1'b0}}, word_count}, 32'd4);
    checkOutput("t3_done", {31'd0, done}, 32'd1);
    checkOutput("t3_ready", {31'd0, in_ready}, 32'd0);
    step();

    // Illegal op_sel aborts after one legal write.
    startPulse();
    applyStimulus(5'd19, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0010, 26'd0, 1'b0, 1'b1, 4);
    applyStimulus(5'd28, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'd1, 1'b0, 1'b1, 4);
    step(); sample();
    checkOutput("t4_err", {31'd0, err}, 32'd1);
    checkOutput("t4_done", {31'd0, done}, 32'd1);
    checkOutput("t4_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("t4_count", {{(31-AW){1'b0}}, word_count}, 32'd1);
    step();

    // Start coincident with valid wins; restart mid-load rewinds the pointer.
    op_sel = 5'd15; in_valid = 1'b1; start = 1'b1;
    sb.delete(); model_ptr = '0;
    sample();
    checkOutput("t5_start_wins", {31'd0, in_ready}, 32'd0);
    step();
    start = 1'b0; in_valid = 1'b0;
    sample();
    checkOutput("t5_err_clr", {31'd0, err}, 32'd0);
    step();
    for (int i = 0; i < 3; i++)
      applyStimulus(5'd17, 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(i * 3 + 1), 26'd0, 1'b0, 1'b1, 4);
    step(); step();
    startPulse();
    applyStimulus(5'd23, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3ffffff, 1'b1, 1'b1, 4);
    step(); sample();
    checkOutput("t5_count", {{(31-AW){1'b0}}, word_count}, 32'd1);
    checkOutput("t5_err", {31'd0, err}, 32'd0);
    checkOutput("t5_done", {31'd0, done}, 32'd1);
    step();

    // Reset in the write cycle suppresses the write.
    startPulse();
    applyStimulus(5'd7, 5'd0, 5'd5, 5'd6, 5'd3, 16'h0, 26'd0, 1'b0, 1'b1, 4);
    reset = 1'b1;
    sb.delete();
    sample();
    checkOutput("t6_we_blocked", {31'd0, imem_we}, 32'd0);
    step();
    reset = 1'b0;
    sample();
    checkOutput("t6_flags", {28'd0, busy, done, err, cpu_hold}, 32'h1);
    checkOutput("t6_count", {{(31-AW){1'b0}}, word_count}, 32'd0);
    checkOutput("t6_wdata", imem_wdata, 32'd0);
    checkOutput("t6_cks", checksum, 32'd0);
    step(); step();

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
